// File: rtl/cgra_clock_gate_ctrl.sv
// Per-channel automatic clock-gating controller: closes a channel clock after an idle
// window and reopens it through a fixed-length WAKE phase; FPGA bypass keeps enables high.
module cgra_clock_gate_ctrl #(
    parameter int N_CH        = 4,
    parameter int IDLE_CYCLES = 16,
    parameter int WAKE_CYCLES = 2,
    parameter int CNT_W       = 16,
    parameter int FPGA_BYPASS = 0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  test_en_i,
    input  logic [N_CH-1:0]       auto_en_i,
    input  logic [N_CH-1:0]       force_on_i,
    input  logic [N_CH-1:0]       busy_i,
    input  logic [N_CH-1:0]       wake_req_i,
    output logic [N_CH-1:0]       wake_ack_o,
    output logic [N_CH-1:0]       en_o,
    output logic [N_CH-1:0]       gated_o,
    input  logic                  clr_cnt_i,
    output logic [N_CH*CNT_W-1:0] gate_cnt_o
);

    localparam int IDLE_W = $clog2(IDLE_CYCLES + 1);
    localparam int WAKE_W = $clog2(WAKE_CYCLES + 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_CYCLES - 1);
    localparam logic [IDLE_W-1:0] IDLE_ONE  = IDLE_W'(1);
    localparam logic [WAKE_W-1:0] WAKE_LAST = WAKE_W'(WAKE_CYCLES - 1);
    localparam logic [WAKE_W-1:0] WAKE_ONE  = WAKE_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
    localparam logic              BYPASS    = (FPGA_BYPASS != 0);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_GATED = 2'd1,
        ST_WAKE  = 2'd2
    } gate_state_e;

    logic [N_CH-1:0] fsm_en_s;
    logic [N_CH-1:0] run_s;

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        gate_state_e       state_r, state_s;
        logic [IDLE_W-1:0] idle_cnt_r, idle_cnt_s;
        logic [WAKE_W-1:0] wake_cnt_r, wake_cnt_s;
        logic [CNT_W-1:0]  gate_cnt_r;
        logic              gated_r;
        logic              idle_s;
        logic              gate_inc_s;
        logic              en_s;

        assign idle_s = auto_en_i[k] & ~busy_i[k] & ~force_on_i[k] & ~wake_req_i[k];

        // Next-state, counter updates and enable decode for one channel
        always_comb begin
            state_s    = state_r;
            idle_cnt_s = idle_cnt_r;
            wake_cnt_s = wake_cnt_r;
            gate_inc_s = 1'b0;
            en_s       = 1'b1;
            case (state_r)
                ST_RUN: begin
                    if (!idle_s) begin
                        idle_cnt_s = {IDLE_W{1'b0}};
                    end else if (idle_cnt_r == IDLE_LAST) begin
                        state_s    = ST_GATED;
                        idle_cnt_s = {IDLE_W{1'b0}};
                        gate_inc_s = 1'b1;
                    end else begin
                        idle_cnt_s = idle_cnt_r + IDLE_ONE;
                    end
                end
                ST_GATED: begin
                    en_s = 1'b0;
                    if (wake_req_i[k] | busy_i[k] | force_on_i[k] | ~auto_en_i[k]) begin
                        state_s    = ST_WAKE;
                        wake_cnt_s = {WAKE_W{1'b0}};
                    end else begin
                        state_s = ST_GATED;
                    end
                end
                ST_WAKE: begin
                    // WAKE always runs to completion; inputs are ignored here
                    if (wake_cnt_r == WAKE_LAST) begin
                        state_s    = ST_RUN;
                        wake_cnt_s = {WAKE_W{1'b0}};
                    end else begin
                        wake_cnt_s = wake_cnt_r + WAKE_ONE;
                    end
                end
                default: begin
                    state_s    = ST_RUN;
                    idle_cnt_s = {IDLE_W{1'b0}};
                    wake_cnt_s = {WAKE_W{1'b0}};
                end
            endcase
        end

        // Channel state, counters and registered gated flag
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                state_r    <= ST_RUN;
                idle_cnt_r <= {IDLE_W{1'b0}};
                wake_cnt_r <= {WAKE_W{1'b0}};
                gated_r    <= 1'b0;
            end else begin
                state_r    <= state_s;
                idle_cnt_r <= idle_cnt_s;
                wake_cnt_r <= wake_cnt_s;
                gated_r    <= (state_s == ST_GATED);
            end
        end

        // Saturating gate-event counter; clear wins over a same-edge increment
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                gate_cnt_r <= {CNT_W{1'b0}};
            end else if (clr_cnt_i) begin
                gate_cnt_r <= {CNT_W{1'b0}};
            end else if (gate_inc_s && (gate_cnt_r != CNT_MAX)) begin
                gate_cnt_r <= gate_cnt_r + CNT_ONE;
            end else begin
                gate_cnt_r <= gate_cnt_r;
            end
        end

        assign fsm_en_s[k] = en_s;
        assign run_s[k]    = (state_r == ST_RUN);
        assign gated_o[k]  = gated_r;
        assign gate_cnt_o[k*CNT_W +: CNT_W] = gate_cnt_r;
    end

    assign wake_ack_o = run_s & wake_req_i;
    assign en_o       = fsm_en_s | {N_CH{test_en_i}} | {N_CH{BYPASS}};

endmodule

// File: doc/cgra_clock_gate_ctrl.md
Name: cgra_clock_gate_ctrl

Overview:
Per-channel automatic clock-gating controller for the CGRA. It produces one enable per channel for the downstream clock-gate cells, closing a column or peripheral clock after a programmable idle window. Wake-up uses a request/acknowledge handshake with a fixed settling delay. An FPGA bypass mode keeps every enable high while the controller state and statistics still run, so gating activity can be profiled on the FPGA target.

Parameters:
N_CH, 4, number of gated channels (1..32)
IDLE_CYCLES, 16, consecutive idle cycles before gating (>=1)
WAKE_CYCLES, 2, cycles spent in WAKE before the channel counts as running (>=1)
CNT_W, 16, width of each per-channel gate-event counter
FPGA_BYPASS, 0, 1 = en_o forced all-ones; FSM, gated_o, ack and counters unchanged

Ports:
clk_i  in  1  single clock
rst_i  in  1  synchronous, active-high reset
test_en_i  in  1  scan/test: forces all en_o high; FSM unaffected
auto_en_i  in  N_CH  per-channel permission to auto-gate
force_on_i  in  N_CH  per-channel keep-clock-on override
busy_i  in  N_CH  channel has outstanding work
wake_req_i  in  N_CH  level request for a running clock; held until ack
wake_ack_o  out  N_CH  channel running and request seen (combinational)
en_o  out  N_CH  enable to the clock-gate cell
gated_o  out  N_CH  channel in GATED state (registered)
clr_cnt_i  in  1  clears all event counters
gate_cnt_o  out  N_CH*CNT_W  per-channel saturating count of RUN->GATED transitions; ch k at [k*CNT_W +: CNT_W]

Behaviour:
- Per channel, idle = auto_en_i & ~busy_i & ~force_on_i & ~wake_req_i.
- Each channel has a 3-state FSM (RUN, GATED, WAKE), an idle counter (clog2(IDLE_CYCLES+1) bits) and a wake counter.
- Reset: all FSMs to RUN, all counters 0, en_o = all-ones, gated_o = 0, gate_cnt_o = 0. wake_ack_o = wake_req_i after reset, because the channel is in RUN.
- Reset mid-operation: any state returns to RUN on the next edge. A gated channel therefore re-enables one cycle after rst_i is sampled high.
- RUN: en_o = 1.
  - When idle, idle_cnt increments; any non-idle cycle clears it to 0.
  - If idle and idle_cnt == IDLE_CYCLES-1, go to GATED, clear idle_cnt and increment gate_cnt.
  - So en_o falls in the cycle after the IDLE_CYCLES-th consecutive idle cycle.
- GATED: en_o = 0, gated_o = 1.
  - If any of wake_req_i, busy_i, force_on_i or ~auto_en_i is high, go to WAKE and clear wake_cnt.
- WAKE: en_o = 1, gated_o = 0.
  - wake_cnt increments each cycle; at wake_cnt == WAKE_CYCLES-1, go to RUN.
  - WAKE cannot be aborted. Inputs during WAKE are ignored until RUN is reached.
- wake_ack_o[k] = (state==RUN) & wake_req_i[k], combinational.
  - A request raised in RUN is acked in the same cycle.
  - A request sampled at edge t in GATED is acked in cycle t+WAKE_CYCLES+1.
- Requester rules: hold wake_req_i until ack is seen. While req is high the channel is not idle, so it never gates under a held request. Dropping req before ack is legal: the wake still completes and the channel returns to RUN.
- Simultaneous events:
  - force_on_i or ~auto_en_i in RUN clears idle_cnt.
  - Idle deasserting on the same cycle the count would complete keeps RUN.
- en_o final = fsm_en | test_en_i | FPGA_BYPASS, all combinational from registered state.
- test_en_i never changes FSM state or counters.
- gate_cnt saturates at 2^CNT_W-1 and does not wrap.
  - clr_cnt_i has priority: a clear and an increment on the same edge yield 0.
- Channels are fully independent. No cross-channel arbitration.

Test Plan:
- Reset with busy_i=0, auto_en_i=all-ones, IDLE_CYCLES=16 -> en_o=0xF for exactly 16 cycles after reset release, en_o=0x0 and gated_o=0xF from cycle 17, gate_cnt_o[ch]=1 each.
- Gate ch0, raise wake_req_i[0] at edge t with WAKE_CYCLES=2 -> en_o[0]=1 from t+1, wake_ack_o[0]=1 at t+3. Then drop req -> channel re-gates 16 idle cycles later and gate_cnt[0]=2.
- busy_i[1] pulses for 1 cycle every 10 cycles -> ch1 never gates, gated_o[1]=0 throughout, gate_cnt[1]=0.
- Idle ch2 for 15 cycles, busy on cycle 16, then idle 16 more -> gating happens only after the second window; exactly one event counted.
- test_en_i=1 while ch3 is GATED -> en_o[3]=1 and gated_o[3] stays 1. FPGA_BYPASS=1 build, same stimulus as the first scenario -> en_o stays 0xF while gated_o and gate_cnt match the first scenario.
- CNT_W=2: gate/wake ch0 5 times -> gate_cnt[0] sticks at 3. Assert clr_cnt_i on the same edge as a gating event -> 0. Assert rst_i while ch0 is in WAKE -> RUN on the next cycle, en_o[0]=1.
